serial_full_sub: RTL

//  Bit-serial subtractor: the inverse of the full-adder datapath. One full-subtractor cell plus a borrow flop.

---
 rtl/serial_full_sub_if.sv | 41 ++++
 rtl/serial_full_sub.sv | 119 +++++++++++
 2 files changed

// File: rtl/serial_full_sub_if.sv
// Valid/ready operand and result channels for the bit-serial subtractor.
// The producer/consumer side uses the master modport, the subtractor the slave modport.
interface serial_full_sub_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid,
        output a,
        output b,
        output bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  bout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output bout
    );

endinterface

// File: rtl/serial_full_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first, using a
// single full-subtractor cell and a borrow flop. Operands arrive and results leave
// over valid/ready handshakes; one transaction is in flight at a time.
module serial_full_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_full_sub_if.slave bus,
    output logic            busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;     // partial difference, filled from the MSB side
    logic [WIDTH-1:0] diff_q, diff_d;   // published result, only updated when SHIFT completes
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             ai;
    logic             bi;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shifted;

    // Full-subtractor cell on the current LSBs and the borrow flop.
    assign ai          = a_q[0];
    assign bi          = b_q[0];
    assign d_bit       = ai ^ bi ^ br_q;
    assign br_next     = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign res_shifted = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

    // Next-state and datapath updates for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_shifted;
                // Counter tops out at WIDTH, which still fits CW bits.
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LastBit) begin
                    diff_d  = res_shifted;
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign busy          = (state_q != StIdle);

endmodule
